// File: rtl/product_acc_pkg.sv
// Shared types and constants for product_accumulator and its companion multiplier.
package product_acc_pkg;
  typedef enum logic [2:0] {IDLE, ARM, WAIT, ACC, OUT} state_t;

  localparam int MUL_CYCLES = 4;  // multiplier Start-high cycles until Done
  localparam int WAIT_BLIND = 1;  // leading WAIT cycles where Done is ignored
endpackage

// File: rtl/product_accumulator_if.sv
// Multiplier-side and result-side signals of product_accumulator.
interface product_accumulator_if #(parameter int ACC_W = 10);
  logic             en;
  logic             Done;
  logic [7:0]       P;
  logic             mul_start;
  logic [ACC_W-1:0] sum;
  logic             sum_valid;
  logic             sum_ready;
  logic             ovf;
  logic             err;
  logic             busy;

  modport slave  (input  en, Done, P, sum_ready,
                  output mul_start, sum, sum_valid, ovf, err, busy);
  modport master (output en, Done, P, sum_ready,
                  input  mul_start, sum, sum_valid, ovf, err, busy);
endinterface

// File: rtl/acc_sat_add.sv
// ACC_W accumulator adder with carry out; ACC_SAT_EN selects clamp-on-carry instead of wrap.
module acc_sat_add #(parameter int ACC_W = 10) (
  input  logic [ACC_W-1:0] a,
  input  logic [7:0]       p,
  output logic [ACC_W-1:0] y,
  output logic             co
);
  logic [ACC_W:0] full;

  assign full = {1'b0, a} + {{(ACC_W-7){1'b0}}, p};
  assign co   = full[ACC_W];

`ifdef ACC_SAT_EN
  // A clamped sum carries again on any nonzero product, so it stays clamped.
  assign y = co ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
  assign y = full[ACC_W-1:0];
`endif
endmodule

// File: rtl/product_accumulator.sv
// Sequences N_PROD multiplications, accumulates the products and hands the sum out on valid/ready.
// Build option: ACC_SAT_EN (saturating accumulation, see acc_sat_add).
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int N_PROD  = 4,
  parameter int ACC_W   = 10,
  parameter int TIMEOUT = 15
) (
  input  logic CLK,
  input  logic RSTn,
  product_accumulator_if.slave bus
);
  localparam logic [3:0] LAST    = 4'(N_PROD - 1);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] BLIND   = 8'(WAIT_BLIND);

  state_t           state, nxt;
  logic [3:0]       cnt;
  logic [7:0]       wcnt;
  logic [7:0]       p_q;
  logic [ACC_W-1:0] sum_q, add_y;
  logic             add_co, done_ok;
  logic             mul_start_q, sum_valid_q, ovf_q, err_q, busy_q;

  assign done_ok = bus.Done && (wcnt >= BLIND);

  acc_sat_add #(.ACC_W(ACC_W)) u_add (.a(sum_q), .p(p_q), .y(add_y), .co(add_co));

  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) state <= IDLE;
    else       state <= nxt;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (bus.en) nxt = ARM;
      ARM:     nxt = WAIT;
      WAIT:    if (done_ok) nxt = ACC;
               else if (wcnt == TO_LAST) nxt = IDLE;
      ACC:     nxt = (cnt == LAST) ? OUT : ARM;
      OUT:     if (bus.sum_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      cnt         <= '0;
      wcnt        <= '0;
      p_q         <= '0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      mul_start_q <= 1'b0;
      sum_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mul_start_q <= (nxt != ARM);
      sum_valid_q <= (nxt == OUT);
      busy_q      <= (nxt != IDLE);
      case (state)
        IDLE: if (bus.en) begin
          cnt   <= '0;
          sum_q <= '0;
          ovf_q <= 1'b0;
          err_q <= 1'b0;
        end
        ARM:  wcnt <= '0;
        WAIT: begin
          wcnt <= wcnt + 8'd1;
          if (done_ok) p_q <= bus.P;
          else if (wcnt == TO_LAST) begin
            err_q <= 1'b1;
            sum_q <= '0;
          end
        end
        ACC: begin
          sum_q <= add_y;
          ovf_q <= ovf_q | add_co;
          cnt   <= cnt + 4'd1;
        end
        default: ;
      endcase
    end

  assign bus.mul_start = mul_start_q;
  assign bus.sum       = sum_q;
  assign bus.sum_valid = sum_valid_q;
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: three product_accumulator configurations, each driven by a serial-multiplier model.
module tb_product_accumulator;
  import product_acc_pkg::*;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  product_accumulator_if #(.ACC_W(10)) if0 ();
  product_accumulator_if #(.ACC_W(8))  if1 ();
  product_accumulator_if #(.ACC_W(10)) if2 ();

  product_accumulator #(.N_PROD(4), .ACC_W(10), .TIMEOUT(15)) dut0 (.CLK(CLK), .RSTn(RSTn), .bus(if0));
  product_accumulator #(.N_PROD(2), .ACC_W(8),  .TIMEOUT(15)) dut1 (.CLK(CLK), .RSTn(RSTn), .bus(if1));
  product_accumulator #(.N_PROD(1), .ACC_W(10), .TIMEOUT(15)) dut2 (.CLK(CLK), .RSTn(RSTn), .bus(if2));

  logic [7:0] opa [3];
  logic [7:0] opb [3];
  logic       en_r [3];
  logic       rdy_r [3];
  logic       kill;
  int         mc0, mc1, mc2;

  assign if0.en = en_r[0];  assign if0.sum_ready = rdy_r[0];  assign if0.P = opa[0] * opb[0];
  assign if1.en = en_r[1];  assign if1.sum_ready = rdy_r[1];  assign if1.P = opa[1] * opb[1];
  assign if2.en = en_r[2];  assign if2.sum_ready = rdy_r[2];  assign if2.P = opa[2] * opb[2];

  // Multiplier model: Start low re-arms; Done is left stale for one cycle, then rises MUL_CYCLES later.
  always @(posedge CLK) begin
    if (!RSTn) begin mc0 <= 0; if0.Done <= 1'b0; end
    else if (!if0.mul_start) mc0 <= 0;
    else if (mc0 < MUL_CYCLES) begin mc0 <= mc0 + 1; if0.Done <= (mc0 == MUL_CYCLES-1) && !kill; end
  end
  always @(posedge CLK) begin
    if (!RSTn) begin mc1 <= 0; if1.Done <= 1'b0; end
    else if (!if1.mul_start) mc1 <= 0;
    else if (mc1 < MUL_CYCLES) begin mc1 <= mc1 + 1; if1.Done <= (mc1 == MUL_CYCLES-1); end
  end
  always @(posedge CLK) begin
    if (!RSTn) begin mc2 <= 0; if2.Done <= 1'b0; end
    else if (!if2.mul_start) mc2 <= 0;
    else if (mc2 < MUL_CYCLES) begin mc2 <= mc2 + 1; if2.Done <= (mc2 == MUL_CYCLES-1); end
  end

  logic sv [3], ms [3], bz [3], ov [3], er [3];
  int   sm [3];
  assign sv[0] = if0.sum_valid; assign ms[0] = if0.mul_start; assign bz[0] = if0.busy;
  assign ov[0] = if0.ovf;       assign er[0] = if0.err;       assign sm[0] = int'(if0.sum);
  assign sv[1] = if1.sum_valid; assign ms[1] = if1.mul_start; assign bz[1] = if1.busy;
  assign ov[1] = if1.ovf;       assign er[1] = if1.err;       assign sm[1] = int'(if1.sum);
  assign sv[2] = if2.sum_valid; assign ms[2] = if2.mul_start; assign bz[2] = if2.busy;
  assign ov[2] = if2.ovf;       assign er[2] = if2.err;       assign sm[2] = int'(if2.sum);

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Pulse en, then count edges (en-sampling edge = 1) until sum_valid, busy drops, or budget runs out.
  task automatic run(input int i, input int budget, output int edges, output int lows);
    @(negedge CLK); en_r[i] = 1'b1;
    edges = 0; lows = 0;
    do begin
      @(negedge CLK); edges++; en_r[i] = 1'b0;
      if (!ms[i]) lows++;
    end while (!sv[i] && bz[i] && edges < budget);
  endtask

  task automatic ack(input int i);
    rdy_r[i] = 1'b1;
    @(negedge CLK);
    chk("ack_busy", int'(bz[i]), 0);
    chk("ack_valid", int'(sv[i]), 0);
    rdy_r[i] = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         sum;
  } vec_t;

  vec_t tbl [5];
  int   e, l;
`ifdef ACC_SAT_EN
  localparam int SUM_OVF8 = 255;
`else
  localparam int SUM_OVF8 = 194;
`endif

  initial begin
    tbl[0] = '{8'd2,  8'd14, 112};
    tbl[1] = '{8'd0,  8'd0,  0};
    tbl[2] = '{8'd15, 8'd15, 900};
    tbl[3] = '{8'd3,  8'd5,  60};
    tbl[4] = '{8'd15, 8'd14, 840};
    kill = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en_r[i] = 1'b0; rdy_r[i] = 1'b0; opa[i] = 8'd0; opb[i] = 8'd0;
    end

    // Reset values, then mul_start rises on the first edge after release
    @(negedge CLK); @(negedge CLK);
    chk("rst_mul_start", int'(ms[0]), 0);
    chk("rst_sum", sm[0], 0);
    chk("rst_valid", int'(sv[0]), 0);
    chk("rst_ovf", int'(ov[0]), 0);
    chk("rst_err", int'(er[0]), 0);
    chk("rst_busy", int'(bz[0]), 0);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("rel_mul_start", int'(ms[0]), 1);

    for (int v = 0; v < 5; v++) begin
      opa[0] = tbl[v].a; opb[0] = tbl[v].b;
      run(0, 100, e, l);
      chk($sformatf("v%0d_latency", v), e, 29);
      chk($sformatf("v%0d_starts", v), l, 4);
      chk($sformatf("v%0d_sum", v), sm[0], tbl[v].sum);
      chk($sformatf("v%0d_ovf", v), int'(ov[0]), 0);
      chk($sformatf("v%0d_err", v), int'(er[0]), 0);
      ack(0);
    end

    // OUT held by sum_ready low; a second en is ignored
    opa[0] = 8'd2; opb[0] = 8'd14;
    run(0, 100, e, l);
    chk("hold_latency", e, 29);
    for (int c = 0; c < 10; c++) begin
      en_r[0] = (c == 3);
      @(negedge CLK);
      chk("hold_valid", int'(sv[0]), 1);
      chk("hold_sum", sm[0], 112);
    end
    en_r[0] = 1'b0;
    ack(0);
    @(negedge CLK);
    chk("en_not_queued", int'(bz[0]), 0);

    // sum_ready high beforehand: OUT lasts one cycle
    rdy_r[0] = 1'b1;
    run(0, 100, e, l);
    chk("prerdy_latency", e, 29);
    chk("prerdy_sum", sm[0], 112);
    @(negedge CLK);
    chk("prerdy_busy", int'(bz[0]), 0);
    chk("prerdy_valid", int'(sv[0]), 0);
    rdy_r[0] = 1'b0;

    // Done never arrives: abort after 15 WAIT cycles
    kill = 1'b1;
    run(0, 100, e, l);
    chk("to_edges", e, 17);
    chk("to_err", int'(er[0]), 1);
    chk("to_valid", int'(sv[0]), 0);
    chk("to_busy", int'(bz[0]), 0);
    chk("to_sum", sm[0], 0);
    kill = 1'b0;
    @(negedge CLK);
    chk("to_err_sticky", int'(er[0]), 1);
    run(0, 100, e, l);
    chk("to_rerun_latency", e, 29);
    chk("to_rerun_err", int'(er[0]), 0);
    chk("to_rerun_sum", sm[0], 112);
    ack(0);

    // Reset mid-batch during the third product's WAIT
    @(negedge CLK); en_r[0] = 1'b1;
    e = 0;
    do begin
      @(negedge CLK); e++; en_r[0] = 1'b0;
    end while (e < 17);
    chk("mid_partial_sum", sm[0], 56);
    RSTn = 1'b0;
    #1;
    chk("mid_mul_start", int'(ms[0]), 0);
    chk("mid_sum", sm[0], 0);
    chk("mid_valid", int'(sv[0]), 0);
    chk("mid_ovf", int'(ov[0]), 0);
    chk("mid_err", int'(er[0]), 0);
    chk("mid_busy", int'(bz[0]), 0);
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("mid_rel_mul_start", int'(ms[0]), 1);
    run(0, 100, e, l);
    chk("mid_rerun_latency", e, 29);
    chk("mid_rerun_sum", sm[0], 112);
    ack(0);

    // ACC_W=8, N_PROD=2, 15*15 twice overflows
    opa[1] = 8'd15; opb[1] = 8'd15;
    run(1, 100, e, l);
    chk("w8_latency", e, 15);
    chk("w8_starts", l, 2);
    chk("w8_sum", sm[1], SUM_OVF8);
    chk("w8_ovf", int'(ov[1]), 1);
    ack(1);
    opa[1] = 8'd1; opb[1] = 8'd1;
    run(1, 100, e, l);
    chk("w8_clr_sum", sm[1], 2);
    chk("w8_clr_ovf", int'(ov[1]), 0);
    ack(1);

    // N_PROD=1 with a zero product
    opa[2] = 8'd0; opb[2] = 8'd9;
    run(2, 100, e, l);
    chk("n1_latency", e, 8);
    chk("n1_starts", l, 1);
    chk("n1_sum", sm[2], 0);
    ack(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream companion of the 4x4 serial multiplier. Sequences a batch of N_PROD back-to-back multiplications by pulsing the multiplier's active-low Start, captures each 8-bit product P when Done is seen, and accumulates into an ACC_W-bit sum. The sum is presented on a valid/ready output handshake, together with overflow and timeout status.

## Interface
- N_PROD, default 4: products accumulated per batch, range 1..15
- ACC_W, default 10: accumulator width, range 8..16
- TIMEOUT, default 15: maximum WAIT cycles before abort, range 4..255
- CLK  in  1  rising-edge clock
- RSTn  in  1  asynchronous active-low reset
- en  in  1  one-cycle request to start a batch; honoured only in IDLE
- Done  in  1  multiplier completion flag
- P  in  8  multiplier product, valid while Done=1
- mul_start  out  1  registered, drives the multiplier's Start; low = clear and re-arm
- sum  out  ACC_W  accumulated result; stable while sum_valid=1
- sum_valid  out  1  result available
- sum_ready  in  1  consumer accepts the result
- ovf  out  1  sum exceeded 2^ACC_W-1 during this batch
- err  out  1  Done timeout occurred; sticky until the next accepted en
- busy  out  1  high in every state except IDLE

## Operation
- States:
  - IDLE: mul_start=1, busy=0
  - ARM: mul_start=0 for exactly 1 cycle; WAIT counter cleared
  - WAIT: mul_start=1; sample Done
  - ACC: add P to sum; cnt++
  - OUT: sum_valid=1
- Transitions:
  - IDLE→ARM on en=1. This clears sum, cnt and ovf. It also clears err.
  - ARM→WAIT always.
  - WAIT→ACC when Done=1. WAIT ignores Done in its first cycle, because Done may still be settling from the ARM pulse.
  - WAIT→IDLE when the wait counter reaches TIMEOUT. This sets err, clears sum and does not assert sum_valid.
  - ACC→ARM if cnt+1<N_PROD. ACC→OUT if cnt+1==N_PROD.
  - OUT→IDLE on the cycle sum_valid&sum_ready.
- Arithmetic:
  - P is zero-extended to ACC_W+1 bits, then added.
  - Carry out of bit ACC_W-1 sets ovf. ovf stays set through OUT.
- Boundary conditions:
  - en while busy is ignored. No queueing.
  - sum_ready held high before OUT: the handshake completes in the first OUT cycle.
  - sum_ready low: hold OUT indefinitely. sum and ovf do not change.
  - N_PROD=1: ARM, WAIT, ACC, OUT.
  - Product of 0: counted normally.
  - Reset mid-batch, in any state: immediate return to IDLE with all outputs at reset values. The partial sum is discarded.

## Timing
- Reset values:
  - mul_start=0, which holds the multiplier cleared. It goes to 1 on the first edge after RSTn rises.
  - sum=0, sum_valid=0, ovf=0, err=0, busy=0.
- All outputs are registered. No combinational path from in to out.
- Per product with the companion multiplier: ARM 1 cycle, WAIT 5 cycles (1 blind plus 4 multiply), ACC 1 cycle = 7 cycles.
- Batch latency: en sampled → sum_valid=1 after 7*N_PROD+1 edges. Default: 29.
- Throughput: one batch per 7*N_PROD+2 cycles, with sum_ready held high.

## Configuration
- ACC_SAT_EN defined: on carry out, sum clamps to 2^ACC_W-1. It stays clamped for the rest of the batch, and ovf=1.
- ACC_SAT_EN undefined: sum wraps modulo 2^ACC_W, and ovf=1 (sticky for the batch).
- All other behaviour is identical in both builds.

## Structure
- Package product_acc_pkg holds:
  - the state enum (IDLE, ARM, WAIT, ACC, OUT)
  - the multiply-latency constant MUL_CYCLES=4
  - the blind-cycle constant WAIT_BLIND=1
- One sub-module, acc_sat_add:
  - combinational ACC_W adder with carry out
  - saturation muxed in under ACC_SAT_EN
- Top level holds the FSM, cnt, the wait counter and the output registers.

## Test plan
- Defaults; bench multiplier model fed A=2, B=14; en pulse → mul_start low 4 times; sum_valid at edge 29; sum=112 (4×28); ovf=0; err=0.
- ACC_W=8, A=15, B=15, N_PROD=2 → without ACC_SAT_EN: sum=194 (450 mod 256), ovf=1. With ACC_SAT_EN: sum=255, ovf=1.
- sum_ready held low 10 cycles in OUT → sum_valid and sum stable; second en ignored; release sum_ready → IDLE next edge; busy=0.
- Done tied low → after TIMEOUT=15 WAIT cycles: err=1, IDLE, sum_valid never rises. Next en clears err.
- RSTn pulsed low during the 3rd WAIT → outputs read reset values immediately; the following en runs a full correct batch (sum=112).
- N_PROD=1, A=0 → sum_valid after 8 edges; sum=0.
